// File: rtl/pkt_ingress_parser_pkg.sv
// Shared switch package.
// Holds the framing constants (SOF_BYTE, DELIMITER) that the per-port
// output FSMs also rely on, and the ingress parser state encoding.
package pkt_ingress_parser_pkg;

  localparam logic [7:0] SOF_BYTE  = 8'hFF;
  localparam logic [7:0] DELIMITER = 8'h55;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_ADDR = 2'd1,
    PAYLOAD  = 2'd2,
    DISCARD  = 2'd3
  } ingress_state_t;

endpackage

// File: rtl/pkt_ingress_parser_addr_match.sv
// pkt_addr_match: combinational destination-address comparator.
// Compares the destination address byte against every port's configured
// address and returns one mask bit per port. Several ports may match.
// Optional feature macro: PKT_BCAST_EN -- when defined, a DA equal to
// BCAST_ADDR selects all ports.
// Ports:
//   da            in  W_WIDTH          destination address byte
//   port_addr_cfg in  N_PORTS*W_WIDTH  port i address in [8i+7:8i]
//   mask          out N_PORTS          per-port match
module pkt_addr_match
  import pkt_ingress_parser_pkg::*;
#(
  parameter int               W_WIDTH    = 8,
  parameter int               N_PORTS    = 4,
  parameter logic [W_WIDTH-1:0] BCAST_ADDR = 8'hFE
) (
  input  logic [W_WIDTH-1:0]         da,
  input  logic [N_PORTS*W_WIDTH-1:0] port_addr_cfg,
  output logic [N_PORTS-1:0]         mask
);

  logic [N_PORTS-1:0] hit;

  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_cmp
      assign hit[gi] = (da == port_addr_cfg[gi*W_WIDTH +: W_WIDTH]);
    end
  endgenerate

`ifdef PKT_BCAST_EN
  // Broadcast overrides individual matches and selects every port.
  assign mask = (da == BCAST_ADDR) ? {N_PORTS{1'b1}} : hit;
`else
  assign mask = hit;
`endif

endmodule

// File: rtl/pkt_ingress_parser.sv
// pkt_ingress_parser: switch ingress stage.
// Finds SOF in the input byte stream, matches the destination address
// against the per-port addresses and writes payload plus delimiter into
// the matching FIFO(s). SOF and DA are stripped (the output FSMs re-add
// them). Oversized packets are truncated with a forced delimiter.
// Optional feature macro: PKT_BCAST_EN (broadcast DA selects all ports).
// Ports:
//   clk, rst_n     clock / asynchronous active-low reset
//   sw_en          switch enable, gates packet start only
//   data_in        input byte, sampled when data_valid is high
//   data_valid     input byte qualifier
//   port_addr_cfg  per-port address, port i in [8i+7:8i]
//   port_full      per-FIFO almost-full, sampled at DA only
//   wr_en          registered per-FIFO write strobe
//   wr_data        registered shared FIFO write data
//   busy           state is not IDLE
//   drop           one-cycle pulse on reject or truncation
module pkt_ingress_parser
  import pkt_ingress_parser_pkg::*;
#(
  parameter int                 W_WIDTH     = 8,
  parameter int                 N_PORTS     = 4,
  parameter int                 MAX_PAYLOAD = 16,
  parameter logic [W_WIDTH-1:0] BCAST_ADDR  = 8'hFE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sw_en,
  input  logic [W_WIDTH-1:0]         data_in,
  input  logic                       data_valid,
  input  logic [N_PORTS*W_WIDTH-1:0] port_addr_cfg,
  input  logic [N_PORTS-1:0]         port_full,
  output logic [N_PORTS-1:0]         wr_en,
  output logic [W_WIDTH-1:0]         wr_data,
  output logic                       busy,
  output logic                       drop
);

  localparam int               CNT_W   = $clog2(MAX_PAYLOAD + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PAYLOAD);

  ingress_state_t     state_reg, state_next;
  logic [N_PORTS-1:0] mask_reg, mask_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [N_PORTS-1:0] wr_en_next;
  logic [W_WIDTH-1:0] wr_data_next;
  logic               drop_next;

  logic [N_PORTS-1:0] match;
  logic               addr_ok;
  logic               is_delim;
  logic               has_room;

  pkt_addr_match #(
    .W_WIDTH    (W_WIDTH),
    .N_PORTS    (N_PORTS),
    .BCAST_ADDR (BCAST_ADDR)
  ) u_addr_match (
    .da            (data_in),
    .port_addr_cfg (port_addr_cfg),
    .mask          (match)
  );

  // A packet is taken only if some port matches and none of the
  // selected FIFOs lacks room for a worst-case packet.
  assign addr_ok  = (match != '0) && ((match & port_full) == '0);
  assign is_delim = (data_in == DELIMITER);
  assign has_room = (count_reg < MAX_CNT);

  // State register (plus the mask/count datapath that moves with it).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      mask_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      mask_reg  <= mask_next;
      count_reg <= count_next;
    end
  end

  // Next-state logic. Invalid cycles hold everything.
  always_comb begin
    state_next = state_reg;
    mask_next  = mask_reg;
    count_next = count_reg;
    if (data_valid) begin
      case (state_reg)
        IDLE: begin
          if (sw_en && (data_in == SOF_BYTE)) state_next = GET_ADDR;
        end
        GET_ADDR: begin
          if (addr_ok) begin
            mask_next  = match;
            count_next = '0;
            state_next = PAYLOAD;
          end else begin
            state_next = DISCARD;
          end
        end
        PAYLOAD: begin
          if (is_delim) begin
            state_next = IDLE;
          end else if (has_room) begin
            count_next = count_reg + CNT_W'(1);
          end else begin
            state_next = DISCARD;
          end
        end
        DISCARD: begin
          if (is_delim) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output logic, computed one cycle ahead and registered below.
  always_comb begin
    wr_en_next   = '0;
    wr_data_next = wr_data;
    drop_next    = 1'b0;
    if (data_valid) begin
      case (state_reg)
        GET_ADDR: begin
          if (!addr_ok) drop_next = 1'b1;
        end
        PAYLOAD: begin
          wr_en_next = mask_reg;
          if (is_delim || has_room) begin
            wr_data_next = data_in;
          end else begin
            // Truncate: close the FIFO packet with a forced delimiter.
            wr_data_next = DELIMITER;
            drop_next    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= '0;
      wr_data <= '0;
      drop    <= 1'b0;
    end else begin
      wr_en   <= wr_en_next;
      wr_data <= wr_data_next;
      drop    <= drop_next;
    end
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: doc/pkt_ingress_parser.md
# pkt_ingress_parser

Switch ingress stage. It accepts the serial input byte stream, detects the start-of-frame, and matches the destination address byte against each output port's configured address. It writes the payload and the terminating delimiter into the matching per-port FIFO(s). The FIFOs feed the per-port output FSMs, which re-prepend SOF and address; this block therefore strips both.

## Interface
- `W_WIDTH`, 8: byte width. Only 8 is supported.
- `N_PORTS`, 4: number of output ports / FIFOs.
- `MAX_PAYLOAD`, 16: maximum number of non-delimiter payload bytes per packet.
- `BCAST_ADDR`, 8'hFE: broadcast destination. Used only under `PKT_BCAST_EN`.
- `clk`, in, 1: the block's single clock. All logic is on the rising edge.
- `rst_n`, in, 1: reset. Asynchronous, active-low.
- `sw_en`, in, 1: switch enable. Gates the start of a packet only.
- `data_in`, in, W_WIDTH: input stream byte.
- `data_valid`, in, 1: `data_in` is sampled on cycles where this is high.
- `port_addr_cfg`, in, N_PORTS*W_WIDTH: port i's address is in bits [8i+7:8i].
- `port_full`, in, N_PORTS: FIFO almost-full, meaning fewer than MAX_PAYLOAD+1 free entries.
- `wr_en`, out, N_PORTS: per-FIFO write strobe. Registered.
- `wr_data`, out, W_WIDTH: shared FIFO write data. Registered.
- `busy`, out, 1: high whenever the state is not IDLE.
- `drop`, out, 1: one-cycle pulse when a packet is rejected or truncated.

## Operation
- Packet format on `data_in`: SOF 8'hFF, DA, payload bytes, DELIMITER 8'h55. The payload never contains 8'h55.
- IDLE:
  - Bytes other than a valid SOF are ignored.
  - A valid byte of 8'hFF with `sw_en`=1 moves to GET_ADDR.
- GET_ADDR, on a valid byte:
  - `mask[i]` = (`data_in` == port i's configured address). Multiple matches write all of the matching ports.
  - If `mask`==0, or if (`mask` & `port_full`) != 0: pulse `drop` and go to DISCARD.
  - Otherwise latch `mask`, clear the payload counter, and go to PAYLOAD.
  - `port_full` is sampled only here.
- PAYLOAD, on each valid byte:
  - If the byte is 8'h55: write it and go to IDLE.
  - Else if count < MAX_PAYLOAD: write it and increment count.
  - Else: write 8'h55 in place of the byte, pulse `drop`, and go to DISCARD.
- DISCARD: consume bytes until a valid 8'h55, then go to IDLE. Nothing is written.
- Every byte written goes to `wr_data` with `wr_en` = latched `mask`. `wr_en` is 0 on all other cycles.
- `sw_en` falling mid-packet has no effect; the packet completes normally.
- Counter width is $clog2(MAX_PAYLOAD+1). The counter saturates and never wraps.

## Timing
- Reset values: state IDLE, `wr_en`=0, `wr_data`=8'h00, `busy`=0, `drop`=0, mask=0, count=0.
- Latency: `wr_en`/`wr_data` appear one cycle after the sampled byte.
- `drop` is asserted in the cycle after the offending byte is sampled. It is exactly one cycle wide.
- Cycles with `data_valid`=0 hold the state and force `wr_en`=0. Gaps may occur anywhere.
- Back-to-back packets are supported: SOF may arrive on the cycle immediately after the delimiter.
- Asserting reset mid-packet returns to IDLE immediately. The FIFOs share `rst_n`, so no partial packet survives.

## Configuration
- Macro `PKT_BCAST_EN`, defined: a DA equal to `BCAST_ADDR` yields mask = all ones. The packet is accepted only if every `port_full` bit is 0; otherwise it is dropped.
- Undefined: `BCAST_ADDR` has no special meaning and is matched like any other address (normally no match, so the packet is dropped).

## Structure
- Shared switch package holds: the SOF_BYTE (8'hFF) and DELIMITER (8'h55) constants, which are also used by the output FSM, and the ingress state encoding (IDLE, GET_ADDR, PAYLOAD, DISCARD).
- One sub-module, `pkt_addr_match`: combinational comparison of DA against `port_addr_cfg` (plus broadcast under the macro), producing `mask[N_PORTS-1:0]`.

## Test plan
All scenarios use port addresses {01,02,03,04} for ports 0..3.
- Unicast: FF 02 11 22 55 -> `wr_en`=4'b0010 for three cycles carrying 11, 22, 55; `drop` stays 0; `busy` falls after the 55.
- No match: FF 09 AA 55 -> one `drop` pulse after 09; no writes; state IDLE after 55.
- Full: `port_full`=4'b0001, then FF 01 AA 55 -> `drop` pulse, no writes. The same stream with `port_full` asserted only after DA writes AA and 55 normally.
- Oversize, with MAX_PAYLOAD=4: FF 03 01 02 03 04 05 06 55 -> port 2 receives 01 02 03 04 55; `drop` pulses at the 05 byte; 06 and 55 are discarded.
- Gating:
  - FF with `sw_en`=0 -> ignored.
  - `sw_en` dropped after DA -> packet completes.
  - `data_valid` gaps inside a packet -> identical FIFO contents.
  - `rst_n` low mid-payload -> all outputs are at reset values in the same cycle.
- Broadcast: FF FE 77 55 -> with `PKT_BCAST_EN`, `wr_en`=4'b1111 for 77 and 55; without it, `drop` and no writes.
